// File: rtl/fifo_pkg.sv
//============================================================================
// Module   : fifo_pkg
// Brief    : Shared sizing helpers and read-mode encoding for sync_fifo_param.
// Revision : 1.0
//============================================================================
`default_nettype none

package fifo_pkg;

  typedef enum logic [0:0] {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } rd_mode_e;

  localparam int c_MIN_DEPTH = 4;
  localparam int c_MAX_DEPTH = 4096;

  // One extra bit beyond the address distinguishes full from empty on wrap.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= c_MIN_DEPTH) && (depth <= c_MAX_DEPTH) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_ram.sv
//============================================================================
// Module   : sdp_ram
// Brief    : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0
//============================================================================
`default_nettype none

module sdp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = ptr_width(DEPTH) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
//============================================================================
// Module   : sync_fifo_param
// Brief    : Single-clock FIFO with registered flags, thresholds, FWFT option.
// Revision : 1.0
//============================================================================
`default_nettype none

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           din,
  output logic                        full,
  output logic                        almost_full,
  output logic                        overflow,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           dout,
  output logic                        valid,
  output logic                        empty,
  output logic                        almost_empty,
  output logic                        underflow,
  output logic [count_width(DEPTH)-1:0] data_count
);

  localparam int       c_PW       = ptr_width(DEPTH);
  localparam int       c_AW       = c_PW - 1;
  localparam int       c_CW       = count_width(DEPTH);
  localparam bit       c_DEPTH_OK = depth_ok(DEPTH);
  localparam rd_mode_e c_MODE     = (FWFT != 0) ? MODE_FWFT : MODE_STD;
  localparam logic     c_AF_RST   = (AF_THRESH <= 0) ? 1'b1 : 1'b0;

  if (!c_DEPTH_OK) begin : g_depth_chk
    $error("sync_fifo_param: DEPTH must be a power of two in 4..4096");
  end

  logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_PW-1:0]   w_wr_ptr_next, w_rd_ptr_next;
  logic [c_CW-1:0]   r_count, w_count_next, w_stage_cnt;
  logic              r_full, r_almost_full, r_empty, r_almost_empty;
  logic              r_valid, r_overflow, r_underflow;
  logic              w_wr_acc, w_rd_acc, w_ram_we, w_ram_re;
  logic              w_valid_next, w_empty_next;
  logic [DATA_W-1:0] w_ram_q;

  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  assign w_wr_ptr_next = r_wr_ptr + {{(c_PW-1){1'b0}}, w_ram_we};
  assign w_rd_ptr_next = r_rd_ptr + {{(c_PW-1){1'b0}}, w_ram_re};
  // Words in RAM plus the word parked in the FWFT output stage, if any.
  assign w_count_next  = (w_wr_ptr_next - w_rd_ptr_next) + w_stage_cnt;

  if (c_MODE == MODE_FWFT) begin : g_fwft
    logic              w_stage_free, w_mem_empty, w_load_ram, w_load_byp;
    logic              r_byp_sel;
    logic [DATA_W-1:0] r_byp_data;

    assign w_stage_free = ~r_valid | w_rd_acc;
    assign w_mem_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_load_ram   = w_stage_free & ~w_mem_empty;
    // A write into an otherwise empty FIFO skips the RAM to keep latency at 1.
    assign w_load_byp   = w_stage_free & w_mem_empty & w_wr_acc;
    assign w_ram_we     = w_wr_acc & ~w_load_byp;
    assign w_ram_re     = w_load_ram;
    assign w_valid_next = w_stage_free ? (w_load_ram | w_load_byp) : 1'b1;
    assign w_empty_next = ~w_valid_next;
    assign w_stage_cnt  = {{(c_CW-1){1'b0}}, w_valid_next};

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        r_byp_sel  <= 1'b0;
        r_byp_data <= '0;
      end else if (w_load_byp) begin
        r_byp_sel  <= 1'b1;
        r_byp_data <= din;
      end else if (w_load_ram) begin
        r_byp_sel  <= 1'b0;
      end
    end

    assign dout = r_byp_sel ? r_byp_data : w_ram_q;
  end else begin : g_std
    assign w_ram_we     = w_wr_acc;
    assign w_ram_re     = w_rd_acc;
    assign w_valid_next = w_rd_acc;
    assign w_empty_next = (w_count_next == '0);
    assign w_stage_cnt  = '0;
    assign dout         = w_ram_q;
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (sys_clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr[c_AW-1:0]),
    .i_wdata (din),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr[c_AW-1:0]),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_valid        <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= c_AF_RST;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_next;
      r_rd_ptr       <= w_rd_ptr_next;
      r_count        <= w_count_next;
      r_valid        <= w_valid_next;
      r_empty        <= w_empty_next;
      r_full         <= (w_count_next == c_CW'(DEPTH));
      r_almost_full  <= (int'(w_count_next) >= AF_THRESH);
      r_almost_empty <= (int'(w_count_next) <= AE_THRESH);
      r_overflow     <= wr_en & r_full;
      r_underflow    <= rd_en & r_empty;
    end
  end

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign overflow     = r_overflow;
  assign valid        = r_valid;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign underflow    = r_underflow;
  assign data_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
//============================================================================
// Module   : tb_sync_fifo_param
// Brief    : Self-checking bench, standard and FWFT instances on shared stimulus.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_sync_fifo_param;

  logic       clk, rst, wr_en, rd_en;
  logic [7:0] din;

  logic       s_full, s_af, s_ovf, s_valid, s_empty, s_ae, s_udf;
  logic [7:0] s_dout;
  logic [4:0] s_cnt;
  logic       f_full, f_af, f_ovf, f_valid, f_empty, f_ae, f_udf;
  logic [7:0] f_dout;
  logic [4:0] f_cnt;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
    .sys_clk(clk), .rst(rst), .wr_en(wr_en), .din(din),
    .full(s_full), .almost_full(s_af), .overflow(s_ovf),
    .rd_en(rd_en), .dout(s_dout), .valid(s_valid), .empty(s_empty),
    .almost_empty(s_ae), .underflow(s_udf), .data_count(s_cnt)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .sys_clk(clk), .rst(rst), .wr_en(wr_en), .din(din),
    .full(f_full), .almost_full(f_af), .overflow(f_ovf),
    .rd_en(rd_en), .dout(f_dout), .valid(f_valid), .empty(f_empty),
    .almost_empty(f_ae), .underflow(f_udf), .data_count(f_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference models: queue contents are the words the FIFO holds.
  logic [7:0] q_s[$];
  logic [7:0] q_f[$];
  logic [7:0] m_d_s;
  logic       m_v_s, m_ovf_s, m_udf_s, m_ovf_f, m_udf_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  task automatic compare_models();
    int ns = q_s.size();
    int nf = q_f.size();
    check("std_status",
          32'({s_full, s_af, s_ovf, s_valid, s_empty, s_ae, s_udf, s_cnt}),
          32'({ns == 16, ns >= 14, m_ovf_s, m_v_s, ns == 0, ns <= 2, m_udf_s, 5'(ns)}));
    check("std_dout", 32'(s_dout), 32'(m_d_s));
    check("fwft_status",
          32'({f_full, f_af, f_ovf, f_valid, f_empty, f_ae, f_udf, f_cnt}),
          32'({nf == 16, nf >= 14, m_ovf_f, nf > 0, nf == 0, nf <= 2, m_udf_f, 5'(nf)}));
    if (nf > 0) check("fwft_dout", 32'(f_dout), 32'(q_f[0]));
  endtask

  task automatic clear_models();
    q_s.delete();
    q_f.delete();
    m_d_s   = 8'h00;
    m_v_s   = 1'b0;
    m_ovf_s = 1'b0;
    m_udf_s = 1'b0;
    m_ovf_f = 1'b0;
    m_udf_f = 1'b0;
  endtask

  // One clock of stimulus; models advance from the pre-edge occupancy.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit s_was_full  = (q_s.size() == 16);
    bit s_was_empty = (q_s.size() == 0);
    bit f_was_full  = (q_f.size() == 16);
    bit f_was_empty = (q_f.size() == 0);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    m_ovf_s = w & s_was_full;
    m_udf_s = r & s_was_empty;
    if (r && !s_was_empty) begin
      m_d_s = q_s.pop_front();
      m_v_s = 1'b1;
    end else begin
      m_v_s = 1'b0;
    end
    if (w && !s_was_full) q_s.push_back(d);
    m_ovf_f = w & f_was_full;
    m_udf_f = r & f_was_empty;
    if (r && !f_was_empty) void'(q_f.pop_front());
    if (w && !f_was_full) q_f.push_back(d);
    compare_models();
  endtask

  // Asserted away from a clock edge so the outputs must clear asynchronously.
  task automatic apply_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    #2;
    clear_models();
    compare_models();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_models();
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
    logic       v;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Hand-derived FWFT expectations after a fresh reset.
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 1, 1'b1, 8'hA5};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1, 1'b1, 8'hA5};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 8'h11, 1, 1'b1, 8'h11};
    tbl[4] = '{1'b1, 1'b0, 8'h22, 2, 1'b1, 8'h11};
    tbl[5] = '{1'b1, 1'b1, 8'h33, 2, 1'b1, 8'h22};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h33};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00};

    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    clear_models();
    #1;
    apply_reset();

    // Fill to full, then one write too many.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i + 1));
      if (i == 12) check("af_below_14", 32'(s_af), 32'd0);
      if (i == 13) check("af_at_14", 32'(s_af), 32'd1);
    end
    check("full_at_16", 32'(s_full), 32'd1);
    check("count_16", 32'(s_cnt), 32'd16);
    step(1'b1, 1'b0, 8'hFF);
    check("ovf_17th", 32'(s_ovf), 32'd1);
    check("count_stays_16", 32'(s_cnt), 32'd16);

    // Drain in standard mode, then one read too many.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("std_rd_order", 32'({s_valid, s_dout}), 32'({1'b1, 8'(i + 1)}));
    end
    check("empty_after_drain", 32'(s_empty), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    check("udf_extra_rd", 32'({s_udf, s_valid}), 32'b10);

    // FWFT hand table.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].d);
      check("tbl_cnt", 32'(f_cnt), 32'(tbl[i].cnt));
      check("tbl_valid_empty", 32'({f_valid, f_empty}), 32'({tbl[i].v, ~tbl[i].v}));
      if (tbl[i].v) check("tbl_dout", 32'(f_dout), 32'(tbl[i].dout));
    end

    // Half-full streaming across pointer wrap.
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h80 + i));
    check("stream_count_std", 32'(s_cnt), 32'd8);
    check("stream_count_fwft", 32'(f_cnt), 32'd8);

    // Write while full with a simultaneous read.
    apply_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 8'hEE);
    check("full_rw_std", 32'({s_ovf, s_cnt}), 32'({1'b1, 5'd15}));
    check("full_rw_fwft", 32'({f_ovf, f_cnt}), 32'({1'b1, 5'd15}));

    // Reset mid-burst at count 9; stale data must be gone.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    check("pre_rst_count", 32'(s_cnt), 32'd9);
    apply_reset();
    check("post_rst_flags", 32'({s_cnt, f_cnt, s_empty, f_valid}), 32'({5'd0, 5'd0, 1'b1, 1'b0}));
    step(1'b1, 1'b0, 8'h3C);
    check("fwft_first_3c", 32'({f_valid, f_dout}), 32'({1'b1, 8'h3C}));
    step(1'b0, 1'b1, 8'h00);
    check("std_first_3c", 32'({s_valid, s_dout}), 32'({1'b1, 8'h3C}));

    // Random traffic with shifting write/read bias.
    apply_reset();
    for (int blk = 0; blk < 4; blk++) begin
      int wp = (blk == 0) ? 80 : (blk == 1) ? 30 : 55;
      int rp = (blk == 0) ? 30 : (blk == 1) ? 80 : 50;
      for (int i = 0; i < 120; i++) begin
        step(1'($urandom_range(99) < wp), 1'($urandom_range(99) < rp), 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO in synthesizable RTL, replacing vendor FIFO IP where no clock crossing is needed. Provides configurable width and depth, registered status flags, programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable standard or first-word-fall-through (FWFT) read mode. Sits between a producer (fifo_wr-style writer) and a consumer (fifo_rd-style reader) in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (1..256)
DEPTH, 16, capacity in words; power of two, 4..4096
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
FWFT, 0, 0 = standard read (dout 1 cycle after rd_en); 1 = first-word-fall-through

Ports:
sys_clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request
din  in  DATA_W  write data
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
overflow  out  1  one-cycle pulse: wr_en while full (write dropped)
rd_en  in  1  read request (FWFT: pop acknowledge of current dout)
dout  out  DATA_W  read data
valid  out  1  dout holds a valid word
empty  out  1  standard: count == 0; FWFT: !valid
almost_empty  out  1  count <= AE_THRESH
underflow  out  1  one-cycle pulse: rd_en while empty (read ignored)
data_count  out  $clog2(DEPTH)+1  words held, including the FWFT output stage

Behaviour:
- Reset (async assert, sync release): pointers = 0, count = 0, dout = 0, valid = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0 (or 1 if AF_THRESH == 0), overflow = underflow = 0. Memory contents are not reset.
- Reset mid-operation: all stored data is discarded; the first write after release is the first word read.
- Accept rules: write accepted = wr_en & !full; read accepted = rd_en & !empty. Both evaluate against the current-cycle registered flags.
- Simultaneous accepted write and read: count unchanged; both pointers advance.
- Write while full with rd_en: write rejected, read accepted, overflow pulses. Read while empty with wr_en: read ignored, write accepted, underflow pulses.
- Pointers: $clog2(DEPTH)+1 bits with an extra wrap bit; address = low bits; wrap-around is natural modulo DEPTH.
- All flags and data_count are registered and updated in the same cycle as the pointer change (next-state computed combinationally from the accept decisions).
- Standard mode: on an accepted read, dout and valid = 1 appear the next cycle. valid = 0 in any cycle after no accepted read. dout holds its last value otherwise.
- FWFT mode: when the output stage is empty and memory is non-empty, the head word is prefetched into dout and valid rises 1 cycle after it is written (write-to-valid latency = 1). rd_en with valid pops the word; the next word is presented in the following cycle with no bubble when available. Total capacity, output stage included, = DEPTH.
- Errors: overflow and underflow are registered pulses, high for exactly the cycle after the offending request, and do not change state.

Decomposition:
- Package fifo_pkg: ptr_width/count_width constant functions ($clog2 wrappers) and a localparam check for DEPTH being a power of two (elaboration $error otherwise).
- One sub-module: sdp_ram (simple dual-port RAM with one write port and one registered read port, DATA_W x DEPTH, inferred block or distributed RAM). FIFO control, flags, and FWFT stage live in sync_fifo_param.

Test Plan:
- Reset then write 0x01..0x10 (DEPTH=16, FWFT=0) -> full=1 after 16th write, almost_full from count 14, data_count=16; 17th wr_en -> overflow pulse, count stays 16.
- Read 16 words standard mode -> dout 0x01..0x10 in order, each valid 1 cycle after rd_en; empty=1 after last; extra rd_en -> underflow pulse, valid=0.
- Continuous wr_en & rd_en at half-full across 40 cycles -> count constant 8, pointers wrap twice, data order preserved.
- FWFT=1: single write 0xA5 to empty FIFO -> valid=1, dout=0xA5 next cycle, data_count=1; rd_en -> valid=0, empty=1 next cycle.
- Write while full with rd_en=1 -> read accepted, write dropped, overflow=1, count=15.
- Assert rst mid-burst at count=9 -> all outputs return to reset values asynchronously; after release, new word 0x3C is the first one read.
